// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling at a runtime bit period,
// one-deep holding register with valid/ack handshake, framing and overrun flags.
module uart_rx_framer #(
    parameter int CPD_W = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             rx_line,
    input  logic [CPD_W-1:0] cycles_per_databit,
    input  logic             rx_ack,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_done,
    output logic             rx_busy,
    output logic             framing_error,
    output logic             overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DELIVER,
        FRAMEERR,
        WAIT_IDLE
    } state_t;

    state_t           state, nextState;
    logic             syncA, sRx;
    logic [CPD_W-1:0] cpdQ, bitTmr;
    logic [3:0]       bitCnt;
    logic [7:0]       shiftReg;
    logic             halfHit, fullHit;

    // bitTmr counts edges since the last sample point, starting at 1
    assign halfHit = (bitTmr == (cpdQ >> 1));
    assign fullHit = (bitTmr == cpdQ);
    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            syncA <= 1'b1;
            sRx   <= 1'b1;
        end else begin
            syncA <= rx_line;
            sRx   <= syncA;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (!sRx) nextState = START;
            START:     if (halfHit) nextState = sRx ? IDLE : DATA;
            DATA:      if (fullHit && bitCnt == 4'd7) nextState = STOP;
            STOP:      if (fullHit) nextState = sRx ? DELIVER : FRAMEERR;
            DELIVER:   nextState = IDLE;
            FRAMEERR:  nextState = WAIT_IDLE;
            WAIT_IDLE: if (sRx) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpdQ     <= '0;
            bitTmr   <= '0;
            bitCnt   <= 4'd0;
            shiftReg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (!sRx) begin
                        cpdQ   <= cycles_per_databit;
                        bitTmr <= CPD_W'(1);
                        bitCnt <= 4'd0;
                    end
                end
                START: bitTmr <= halfHit ? CPD_W'(1) : bitTmr + CPD_W'(1);
                DATA: begin
                    if (fullHit) begin
                        shiftReg <= {sRx, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 4'd1;
                        bitTmr   <= CPD_W'(1);
                    end else begin
                        bitTmr <= bitTmr + CPD_W'(1);
                    end
                end
                STOP: bitTmr <= fullHit ? CPD_W'(1) : bitTmr + CPD_W'(1);
                default: ;
            endcase
        end
    end

    // Ack and a new byte on the same edge: the new byte wins and valid stays up
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_done       <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rx_done       <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            if (rx_ack) rx_valid <= 1'b0;
            if (state == DELIVER) begin
                rx_data  <= shiftReg;
                rx_valid <= 1'b1;
                rx_done  <= 1'b1;
                overrun  <= rx_valid & ~rx_ack;
            end
            if (state == FRAMEERR) framing_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: drives serial frames at 50 clocks per bit and checks the
// outputs every cycle against an event-schedule model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx_framer;
    localparam int CPD = 50;
    localparam int H   = CPD / 2;
    localparam int LAT = 2;                    // synchroniser delay from line edge to D

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_line = 1'b1;
    logic       rx_ack = 1'b0;
    logic [9:0] cpd = 10'd50;
    logic [7:0] rx_data;
    logic       rx_valid, rx_done, rx_busy, framing_error, overrun;

    always #1000 clk = ~clk;

    uart_rx_framer #(.CPD_W(10)) dut (
        .clk(clk), .resetn(resetn), .rx_line(rx_line), .cycles_per_databit(cpd),
        .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid), .rx_done(rx_done),
        .rx_busy(rx_busy), .framing_error(framing_error), .overrun(overrun)
    );

    typedef struct {
        int         at;
        bit         fe;
        logic [7:0] data;
    } ev_t;

    ev_t        evQ[$];
    int         busyLo[$], busyHi[$];
    logic [7:0] mData = 8'h00;
    bit         mValid = 1'b0;
    int         cyc = 0, total = 0, bad = 0;
    int         lastDoneCyc = -1, doneCount = 0, ovrCount = 0, feCount = 0, lastOvrCyc = -1;
    bit         autoAck = 1'b0, manualAck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) rx_ack = autoAck ? rx_done : manualAck;

    // Model: frames schedule their output events by arithmetic from the line fall cycle.
    always @(posedge clk) begin
        bit   ack, oldValid, eDone, eFe, eOvr, eBusy;
        ev_t  e;
        cyc++;
        ack = rx_ack;
        eDone = 0; eFe = 0; eOvr = 0; eBusy = 0;
        if (!resetn) begin
            evQ.delete(); busyLo.delete(); busyHi.delete();
            mData = 8'h00; mValid = 1'b0;
        end else begin
            oldValid = mValid;
            if (ack) mValid = 1'b0;
            if (evQ.size() > 0 && evQ[0].at == cyc) begin
                e = evQ.pop_front();
                if (e.fe) eFe = 1;
                else begin
                    eDone = 1; eOvr = oldValid && !ack;
                    mData = e.data; mValid = 1'b1;
                end
            end
            while (busyHi.size() > 0 && busyHi[0] < cyc) begin
                void'(busyLo.pop_front()); void'(busyHi.pop_front());
            end
            foreach (busyLo[i]) if (busyLo[i] <= cyc && cyc <= busyHi[i]) eBusy = 1;
        end
        #1;
        if (resetn) begin
            check("rx_done", rx_done, eDone);
            check("framing_error", framing_error, eFe);
            check("overrun", overrun, eOvr);
            check("rx_valid", rx_valid, mValid);
            check("rx_data", rx_data, mData);
            check("rx_busy", rx_busy, eBusy);
            if (rx_done) begin lastDoneCyc = cyc; doneCount++; end
            if (overrun) begin lastOvrCyc = cyc; ovrCount++; end
            if (framing_error) feCount++;
        end
    end

    // Called at a negedge; returns at the negedge ending the frame (or its held-low tail).
    task automatic sendFrame(input logic [7:0] b, input bit stopOk, input int lowHold);
        int         c, d;
        logic [9:0] bits;
        c = cyc + 1;
        d = c + LAT;
        evQ.push_back('{at: d + H + 9*CPD + 1, fe: !stopOk, data: b});
        busyLo.push_back(d);
        busyHi.push_back(stopOk ? d + H + 9*CPD : c + 10*CPD + lowHold + 1);
        bits = {stopOk, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = bits[i];
            repeat (CPD) @(negedge clk);
        end
        if (!stopOk) repeat (lowHold) @(negedge clk);
        rx_line = 1'b1;
    endtask

    task automatic ack1();
        @(posedge clk); #2 manualAck = 1'b1;
        @(posedge clk); #2 manualAck = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c0, d0, n0;
        logic [7:0] abortByte;
        repeat (2) @(negedge clk);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset rx_busy", rx_busy, 1'b0);
        check("reset pulses", {rx_done, framing_error, overrun}, 3'b000);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // 00 then 01, acked manually
        c0 = cyc + 1;
        sendFrame(8'h00, 1'b1, 0);
        check("done time 00", lastDoneCyc, c0 + 478);
        check("data 00", rx_data, 8'h00);
        repeat (20) @(negedge clk);
        check("valid held", rx_valid, 1'b1);
        ack1();
        check("valid cleared", rx_valid, 1'b0);
        ack1();
        check("ack idle no effect", rx_valid, 1'b0);
        c0 = cyc + 1;
        sendFrame(8'h01, 1'b1, 0);
        check("done time 01", lastDoneCyc, c0 + 478);
        check("data 01", rx_data, 8'h01);
        ack1();

        // back-to-back A5, 3C acked on rx_done
        autoAck = 1'b1;
        n0 = doneCount;
        sendFrame(8'hA5, 1'b1, 0);
        check("data A5", rx_data, 8'hA5);
        sendFrame(8'h3C, 1'b1, 0);
        repeat (5) @(negedge clk);
        autoAck = 1'b0;
        check("b2b count", doneCount - n0, 2);
        check("b2b data 3C", rx_data, 8'h3C);
        check("b2b no overrun", ovrCount, 0);

        // 11 then 22 unacked
        sendFrame(8'h11, 1'b1, 0);
        sendFrame(8'h22, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("overrun count", ovrCount, 1);
        check("overrun on 2nd done", lastOvrCyc, lastDoneCyc);
        check("overrun data", rx_data, 8'h22);
        check("overrun valid", rx_valid, 1'b1);
        ack1();

        // 10-clock low glitch is a false start
        c0 = cyc + 1; d0 = c0 + LAT;
        n0 = doneCount;
        busyLo.push_back(d0); busyHi.push_back(d0 + H - 1);
        rx_line = 1'b0;
        repeat (10) @(negedge clk);
        rx_line = 1'b1;
        while (cyc < d0 + H - 1) @(negedge clk);
        check("glitch busy", rx_busy, 1'b1);
        while (cyc < d0 + 26) @(negedge clk);
        check("glitch idle D+26", rx_busy, 1'b0);
        repeat (40) @(negedge clk);
        check("glitch no done", doneCount - n0, 0);
        check("glitch no fe", feCount, 0);

        // 55 with low stop held 200 clocks, then 0F
        sendFrame(8'h55, 1'b0, 200);
        check("fe count", feCount, 1);
        check("fe data kept", rx_data, 8'h22);
        check("fe busy waiting", rx_busy, 1'b1);
        repeat (10) @(negedge clk);
        check("fe back idle", rx_busy, 1'b0);
        sendFrame(8'h0F, 1'b1, 0);
        check("data 0F", rx_data, 8'h0F);
        check("valid 0F", rx_valid, 1'b1);

        // reset at mid-bit 4 of a frame
        abortByte = 8'hC3;
        c0 = cyc + 1; d0 = c0 + LAT;
        busyLo.push_back(d0); busyHi.push_back(d0 + 100000);
        rx_line = 1'b0;
        repeat (CPD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_line = abortByte[i];
            repeat (CPD) @(negedge clk);
        end
        rx_line = abortByte[4];
        repeat (H) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst rx_data", rx_data, 8'h00);
        check("rst rx_valid", rx_valid, 1'b0);
        check("rst rx_busy", rx_busy, 1'b0);
        check("rst pulses", {rx_done, framing_error, overrun}, 3'b000);
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        c0 = cyc + 1;
        sendFrame(8'h7E, 1'b1, 0);
        check("done time 7E", lastDoneCyc, c0 + 478);
        check("data 7E", rx_data, 8'h7E);
        check("valid 7E", rx_valid, 1'b1);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #40000000;
        bad++;
        $display("FAIL watchdog: got=timeout want=finish at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
